// File: rtl/led_adc_scheduler.sv
// RED / IR / DARK time-multiplexed sampling sequencer for the pulse-oximeter front end.
// Each frame settles, averages 2^AVG_LOG2 ADC samples per phase, then publishes all three results.
module led_adc_scheduler #(
  parameter int SETTLE_CYCLES = 4,
  parameter int AVG_LOG2      = 2
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       cfg_valid,
  input  logic [6:0] red_dc_cfg,
  input  logic [3:0] red_pga_cfg,
  input  logic [6:0] ir_dc_cfg,
  input  logic [3:0] ir_pga_cfg,
  input  logic [7:0] ADC,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic [7:0] RED_ADC_Value,
  output logic [7:0] IR_ADC_Value,
  output logic [7:0] DARK_ADC_Value,
  output logic       sample_valid,
  output logic       busy
);

  localparam int AW = 8 + AVG_LOG2;
  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] ACC_LAST = 16'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE, RED_SETTLE, RED_ACC, IR_SETTLE, IR_ACC, DARK_SETTLE, DARK_ACC, PUBLISH
  } state_t;

  // Assertion is immediate; release is delayed two edges so the FSM starts cleanly.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [6:0] red_dc_sh_q, red_dc_sh_d, ir_dc_sh_q, ir_dc_sh_d;
  logic [3:0] red_pga_sh_q, red_pga_sh_d, ir_pga_sh_q, ir_pga_sh_d;
  logic [6:0] red_dc_new, ir_dc_new;
  logic [3:0] red_pga_new, ir_pga_new;

  always_comb begin
    red_dc_sh_d  = red_dc_sh_q;
    red_pga_sh_d = red_pga_sh_q;
    ir_dc_sh_d   = ir_dc_sh_q;
    ir_pga_sh_d  = ir_pga_sh_q;
    if (cfg_valid) begin
      red_dc_sh_d  = red_dc_cfg;
      red_pga_sh_d = red_pga_cfg;
      ir_dc_sh_d   = ir_dc_cfg;
      ir_pga_sh_d  = ir_pga_cfg;
    end
  end

  // Shadow contents including a same-cycle write, so a strobe on the frame-start edge takes effect.
  assign red_dc_new  = red_dc_sh_d;
  assign red_pga_new = red_pga_sh_d;
  assign ir_dc_new   = ir_dc_sh_d;
  assign ir_pga_new  = ir_pga_sh_d;

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      red_dc_sh_q  <= '0;
      red_pga_sh_q <= '0;
      ir_dc_sh_q   <= '0;
      ir_pga_sh_q  <= '0;
    end else begin
      red_dc_sh_q  <= red_dc_sh_d;
      red_pga_sh_q <= red_pga_sh_d;
      ir_dc_sh_q   <= ir_dc_sh_d;
      ir_pga_sh_q  <= ir_pga_sh_d;
    end
  end

  state_t         state_q;
  logic [15:0]    cnt_q;
  logic [AW-1:0]  acc_q, acc_sum;
  logic [7:0]     avg_res;
  logic [7:0]     red_hold_q, ir_hold_q;
  logic [6:0]     act_ir_dc_q;
  logic [3:0]     act_ir_pga_q;
  logic           led_red_q, led_ir_q, sample_valid_q;
  logic [6:0]     dc_q;
  logic [3:0]     pga_q;
  logic [7:0]     red_out_q, ir_out_q, dark_out_q;

  assign acc_sum = acc_q + AW'(ADC);
  assign avg_res = acc_sum[AW-1:AVG_LOG2];

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      acc_q          <= '0;
      red_hold_q     <= '0;
      ir_hold_q      <= '0;
      act_ir_dc_q    <= '0;
      act_ir_pga_q   <= '0;
      led_red_q      <= 1'b0;
      led_ir_q       <= 1'b0;
      dc_q           <= '0;
      pga_q          <= '0;
      red_out_q      <= '0;
      ir_out_q       <= '0;
      dark_out_q     <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        IDLE, PUBLISH: begin
          led_red_q <= 1'b0;
          led_ir_q  <= 1'b0;
          state_q   <= IDLE;
          if (enable) begin
            state_q      <= RED_SETTLE;
            cnt_q        <= '0;
            act_ir_dc_q  <= ir_dc_new;
            act_ir_pga_q <= ir_pga_new;
            led_red_q    <= 1'b1;
            dc_q         <= red_dc_new;
            pga_q        <= red_pga_new;
          end
        end
        RED_SETTLE, IR_SETTLE, DARK_SETTLE: begin
          if (cnt_q == SET_LAST) begin
            state_q <= state_t'(state_q + 3'd1);
            cnt_q   <= '0;
            acc_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RED_ACC, IR_ACC, DARK_ACC: begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == ACC_LAST) begin
            cnt_q   <= '0;
            state_q <= state_t'(state_q + 3'd1);
            if (state_q == RED_ACC) begin
              red_hold_q <= avg_res;
              led_red_q  <= 1'b0;
              led_ir_q   <= 1'b1;
              dc_q       <= act_ir_dc_q;
              pga_q      <= act_ir_pga_q;
            end else if (state_q == IR_ACC) begin
              ir_hold_q  <= avg_res;
              led_ir_q   <= 1'b0;
              dc_q       <= act_ir_dc_q;
              pga_q      <= act_ir_pga_q;
            end else begin
              red_out_q      <= red_hold_q;
              ir_out_q       <= ir_hold_q;
              dark_out_q     <= avg_res;
              sample_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign LED_RED        = led_red_q;
  assign LED_IR         = led_ir_q;
  assign DC_Comp        = dc_q;
  assign PGA_Gain       = pga_q;
  assign RED_ADC_Value  = red_out_q;
  assign IR_ADC_Value   = ir_out_q;
  assign DARK_ADC_Value = dark_out_q;
  assign sample_valid   = sample_valid_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_led_adc_scheduler.sv
// Directed bench for led_adc_scheduler: table of single frames plus reset, cfg-timing
// and back-to-back sequences, with edge indices counted from the RED_SETTLE entry edge.
module tb_led_adc_scheduler;

  logic       CLK = 1'b0;
  logic       rst_n, enable, cfg_valid;
  logic [6:0] red_dc_cfg, ir_dc_cfg;
  logic [3:0] red_pga_cfg, ir_pga_cfg;
  logic [7:0] ADC;
  logic       LED_RED, LED_IR, sample_valid, busy;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [7:0] RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value;

  led_adc_scheduler #(.SETTLE_CYCLES(4), .AVG_LOG2(2)) dut (
    .CLK(CLK), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid),
    .red_dc_cfg(red_dc_cfg), .red_pga_cfg(red_pga_cfg),
    .ir_dc_cfg(ir_dc_cfg), .ir_pga_cfg(ir_pga_cfg), .ADC(ADC),
    .LED_RED(LED_RED), .LED_IR(LED_IR), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
    .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
    .DARK_ADC_Value(DARK_ADC_Value), .sample_valid(sample_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0]      r_dc, i_dc;
    logic [3:0]      r_pga, i_pga;
    logic [3:0][7:0] rs, is, ds;
    logic [7:0]      er, ei, ed;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_cfg(input vec_t v);
    red_dc_cfg = v.r_dc; red_pga_cfg = v.r_pga;
    ir_dc_cfg  = v.i_dc; ir_pga_cfg  = v.i_pga;
  endtask

  // Edge 0 enters RED_SETTLE; phase samples land on edges 5-8, 13-16, 21-24; edge 24 enters PUBLISH.
  task automatic do_frame(input vec_t v, input int cfg_at, input logic en_tail, input string tag);
    for (int e = 0; e <= 24; e++) begin
      if (e >= 5 && e <= 8)        ADC = v.rs[e-5];
      else if (e >= 13 && e <= 16) ADC = v.is[e-13];
      else if (e >= 21 && e <= 24) ADC = v.ds[e-21];
      else                         ADC = 8'hA5;
      cfg_valid = (e == cfg_at);
      enable    = (e >= 17) ? en_tail : 1'b1;
      tick();
      if (e == 0) begin
        chk({tag, " red led"}, {LED_RED, LED_IR, busy}, 3'b101);
        chk({tag, " red dc"},  DC_Comp,  v.r_dc);
        chk({tag, " red pga"}, PGA_Gain, v.r_pga);
      end else if (e == 8) begin
        chk({tag, " ir led"},  {LED_RED, LED_IR}, 2'b01);
        chk({tag, " ir dc"},   {DC_Comp, PGA_Gain}, {v.i_dc, v.i_pga});
      end else if (e == 16) begin
        chk({tag, " dark led"}, {LED_RED, LED_IR}, 2'b00);
        chk({tag, " dark dc"},  {DC_Comp, PGA_Gain}, {v.i_dc, v.i_pga});
      end
      if (e == 24) begin
        chk({tag, " valid"}, {sample_valid, busy}, 2'b11);
        chk({tag, " red res"},  RED_ADC_Value,  v.er);
        chk({tag, " ir res"},   IR_ADC_Value,   v.ei);
        chk({tag, " dark res"}, DARK_ADC_Value, v.ed);
      end else begin
        chk({tag, " no valid"}, sample_valid, 1'b0);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    tick();
    chk({tag, " idle"}, {busy, LED_RED, LED_IR, sample_valid}, 4'b0000);
  endtask

  function automatic vec_t mk(input logic [6:0] rdc, input logic [3:0] rpga,
                              input logic [6:0] idc, input logic [3:0] ipga,
                              input logic [31:0] rs, input logic [31:0] is,
                              input logic [31:0] ds, input logic [7:0] er,
                              input logic [7:0] ei, input logic [7:0] ed);
    vec_t v;
    v.r_dc = rdc; v.r_pga = rpga; v.i_dc = idc; v.i_pga = ipga;
    v.rs = rs; v.is = is; v.ds = ds; v.er = er; v.ei = ei; v.ed = ed;
    return v;
  endfunction

  vec_t tbl[4];
  vec_t v;
  logic saw_valid;

  initial begin
    tbl[0] = mk(7'd25, 4'd6, 7'd40, 4'd9, 32'h64646464, 32'hC8C8C8C8, 32'h0A0A0A0A, 8'd100, 8'd200, 8'd10);
    tbl[1] = mk(7'd25, 4'd6, 7'd40, 4'd9, 32'h0D0C0B0A, 32'h01020304, 32'hFCFDFEFF, 8'd11, 8'd2, 8'd253);
    tbl[2] = mk(7'd127, 4'd15, 7'd127, 4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd255, 8'd255, 8'd255);
    tbl[3] = mk(7'd0, 4'd0, 7'd1, 4'd1, 32'h00000003, 32'h00000000, 32'h03030303, 8'd0, 8'd0, 8'd3);

    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; ADC = 8'd0;
    red_dc_cfg = '0; red_pga_cfg = '0; ir_dc_cfg = '0; ir_pga_cfg = '0;
    #2;
    chk("reset outs", {LED_RED, LED_IR, DC_Comp, PGA_Gain, sample_valid, busy}, '0);
    chk("reset res", {RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value}, '0);
    tick(); tick();
    rst_n = 1'b1;
    enable = 1'b1;
    tick();
    chk("sync release edge1", busy, 1'b0);
    enable = 1'b0;
    repeat (3) tick();
    chk("idle after release", busy, 1'b0);

    foreach (tbl[i]) begin
      load_cfg(tbl[i]);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      do_frame(tbl[i], -1, 1'b0, $sformatf("vec%0d", i));
      expect_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d hold res", i), RED_ADC_Value, tbl[i].er);
    end

    // Asynchronous reset in the middle of RED_ACC.
    v = tbl[0];
    load_cfg(v);
    cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    enable = 1'b1; ADC = 8'd50;
    repeat (7) tick();
    chk("pre-reset in acc", {busy, LED_RED}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("async rst outs", {LED_RED, LED_IR, DC_Comp, PGA_Gain, sample_valid, busy}, '0);
    chk("async rst res", {RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value}, '0);
    saw_valid = 1'b0;
    repeat (30) begin
      tick();
      if (sample_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
    end
    chk("held in reset", saw_valid, 1'b0);
    enable = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post-reset idle", {busy, DC_Comp}, '0);

    // Back-to-back frames with mid-frame cfg write, then a bypass write at PUBLISH->RED_SETTLE.
    v = tbl[0];
    load_cfg(v);
    cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    red_dc_cfg = 7'd60;
    do_frame(v, 14, 1'b1, "cfgA");
    v.r_dc = 7'd60;
    red_dc_cfg = 7'd77;
    do_frame(v, -1, 1'b1, "cfgB");
    v.r_dc = 7'd77;
    do_frame(v, 0, 1'b0, "bypass");
    expect_idle("enable drop");
    saw_valid = 1'b0;
    repeat (30) begin
      tick();
      if (sample_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
    end
    chk("stays idle", saw_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
